pixel_resolve_ctrl: RTL

PIXEL_RESOLVE_CTRL -- requirements
Module: pixel_resolve_ctrl

---
 rtl/pixel_resolve_ctrl_pkg.sv | 23 ++
 rtl/pixel_resolve_ctrl_btree_mux.sv | 43 ++++
 rtl/pixel_resolve_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_resolve_ctrl_pkg.sv
// Shared constants for the pixel resolve controller: default sizes,
// configuration field codes and controller state encoding.
package pixel_resolve_ctrl_pkg;

  localparam int RECT_COUNT_DFLT       = 64;
  localparam int RECT_COUNT_WIDTH_DFLT = 6;
  localparam int CFG_DATA_W            = 16;

  // cfg_field codes; codes 6 and 7 are accepted and ignored
  localparam logic [2:0] FLD_X     = 3'd0;
  localparam logic [2:0] FLD_Y     = 3'd1;
  localparam logic [2:0] FLD_W     = 3'd2;
  localparam logic [2:0] FLD_H     = 3'd3;
  localparam logic [2:0] FLD_COLOR = 3'd4;
  localparam logic [2:0] FLD_BG    = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_resolve_ctrl_btree_mux.sv
// Binary-tree priority mux: returns the data of the highest-indexed set
// flag and the OR of all flags. Data is 0 when no flag is set.
module btree_mux #(
  parameter int N  = 64,
  parameter int DW = 6
) (
  input  logic [N-1:0]         flags_in,
  input  logic [N-1:0][DW-1:0] data_in,
  output logic                 flag_out,
  output logic [DW-1:0]        data_out
);

  // Leaves padded to a power of two; node k has children 2k+1 (lower
  // indices) and 2k+2 (higher indices), leaves start at LEAVES-1.
  localparam int LEAVES = (N < 2) ? 2 : (1 << $clog2(N));
  localparam int NODES  = 2 * LEAVES - 1;

  logic [NODES-1:0]         w_f;
  logic [NODES-1:0][DW-1:0] w_d;

  // Reduce bottom-up; the right (higher index) child wins a tie
  always_comb begin
    w_f = '0;
    w_d = '0;
    for (int i = 0; i < N; i++) begin
      w_f[LEAVES-1+i] = flags_in[i];
      w_d[LEAVES-1+i] = data_in[i];
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (w_f[2*k+2]) begin
        w_f[k] = 1'b1;
        w_d[k] = w_d[2*k+2];
      end else if (w_f[2*k+1]) begin
        w_f[k] = 1'b1;
        w_d[k] = w_d[2*k+1];
      end
    end
  end

  assign flag_out = w_f[0];
  assign data_out = w_d[0];

endmodule

// File: rtl/pixel_resolve_ctrl.sv
// Pixel resolve controller: 3-stage pipeline that finds the top-most
// rectangle covering each pixel, with a shadow/active rectangle table
// committed on frame_start after the pipeline has drained.
module pixel_resolve_ctrl
  import pixel_resolve_ctrl_pkg::*;
#(
  parameter int RECT_COUNT       = RECT_COUNT_DFLT,
  parameter int RECT_COUNT_WIDTH = RECT_COUNT_WIDTH_DFLT,
  parameter int COORD_WIDTH      = 16,
  parameter int COLOR_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [RECT_COUNT_WIDTH-1:0] cfg_index,
  input  logic [2:0]                  cfg_field,
  input  logic [CFG_DATA_W-1:0]       cfg_data,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [COORD_WIDTH-1:0]      pix_x,
  input  logic [COORD_WIDTH-1:0]      pix_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COLOR_WIDTH-1:0]      out_color,
  output logic                        out_hit,
  output logic [RECT_COUNT_WIDTH-1:0] out_index,
  output logic                        busy
);

  function automatic logic [COORD_WIDTH-1:0] fit_coord(input logic [CFG_DATA_W-1:0] d);
    logic [COORD_WIDTH+CFG_DATA_W-1:0] t;
    t = {{COORD_WIDTH{1'b0}}, d};
    return t[COORD_WIDTH-1:0];
  endfunction

  function automatic logic [COLOR_WIDTH-1:0] fit_color(input logic [CFG_DATA_W-1:0] d);
    logic [COLOR_WIDTH+CFG_DATA_W-1:0] t;
    t = {{COLOR_WIDTH{1'b0}}, d};
    return t[COLOR_WIDTH-1:0];
  endfunction

  // End coordinates are formed one bit wider so a rectangle touching the
  // top of the coordinate space never wraps back to low coordinates.
  function automatic logic rect_hit(
    input logic [COORD_WIDTH-1:0] px, input logic [COORD_WIDTH-1:0] py,
    input logic [COORD_WIDTH-1:0] rx, input logic [COORD_WIDTH-1:0] ry,
    input logic [COORD_WIDTH-1:0] rw, input logic [COORD_WIDTH-1:0] rh);
    logic [COORD_WIDTH:0] ex;
    logic [COORD_WIDTH:0] ey;
    ex = {1'b0, rx} + {1'b0, rw};
    ey = {1'b0, ry} + {1'b0, rh};
    return (rw != '0) && (rh != '0) && (px >= rx) && ({1'b0, px} < ex) &&
           (py >= ry) && ({1'b0, py} < ey);
  endfunction

  // Shadow (written by cfg) and active (used by the pipeline) tables
  logic [COORD_WIDTH-1:0] r_sh_x  [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_sh_y  [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_sh_w  [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_sh_h  [RECT_COUNT];
  logic [COLOR_WIDTH-1:0] r_sh_c  [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_act_x [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_act_y [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_act_w [RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_act_h [RECT_COUNT];
  logic [COLOR_WIDTH-1:0] r_act_c [RECT_COUNT];
  logic [COLOR_WIDTH-1:0] r_sh_bg;
  logic [COLOR_WIDTH-1:0] r_act_bg;

  state_t r_state;

  logic                        r_vld_p1;
  logic [COORD_WIDTH-1:0]      r_px_p1;
  logic [COORD_WIDTH-1:0]      r_py_p1;
  logic                        r_vld_p2;
  logic                        r_hit_p2;
  logic [RECT_COUNT_WIDTH-1:0] r_idx_p2;

  logic                                      w_stall;
  logic                                      w_adv;
  logic                                      w_accept;
  logic                                      w_pipe_idle;
  logic                                      w_commit;
  logic [RECT_COUNT-1:0]                     w_hit;
  logic [RECT_COUNT-1:0][RECT_COUNT_WIDTH-1:0] w_ids;
  logic                                      w_any_hit;
  logic [RECT_COUNT_WIDTH-1:0]               w_win_idx;
  logic                                      w_hit_out;

  assign w_stall     = out_valid && !out_ready;
  assign w_adv       = !w_stall;
  assign pix_ready   = (r_state == ST_RUN) && !w_stall;
  assign w_accept    = pix_valid && pix_ready;
  assign w_pipe_idle = !r_vld_p1 && !r_vld_p2 && !out_valid;
  assign w_commit    = (r_state == ST_COMMIT);

  // Controller: a frame_start commits only once nothing is in flight, so
  // in-flight pixels always finish against the table they started with
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (frame_start) begin
            busy    <= 1'b1;
            r_state <= (w_pipe_idle && !w_accept) ? ST_COMMIT : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pipe_idle) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_state <= ST_RUN;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Table update: cfg writes go to shadow; during COMMIT the whole shadow
  // copies to active and a same-cycle write overrides its copied entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RECT_COUNT; i++) begin
        r_sh_x[i]  <= '0;
        r_sh_y[i]  <= '0;
        r_sh_w[i]  <= '0;
        r_sh_h[i]  <= '0;
        r_sh_c[i]  <= '0;
        r_act_x[i] <= '0;
        r_act_y[i] <= '0;
        r_act_w[i] <= '0;
        r_act_h[i] <= '0;
        r_act_c[i] <= '0;
      end
      r_sh_bg  <= '0;
      r_act_bg <= '0;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < RECT_COUNT; i++) begin
          r_act_x[i] <= r_sh_x[i];
          r_act_y[i] <= r_sh_y[i];
          r_act_w[i] <= r_sh_w[i];
          r_act_h[i] <= r_sh_h[i];
          r_act_c[i] <= r_sh_c[i];
        end
        r_act_bg <= r_sh_bg;
      end
      if (cfg_we) begin
        case (cfg_field)
          FLD_X: begin
            r_sh_x[cfg_index] <= fit_coord(cfg_data);
            if (w_commit) r_act_x[cfg_index] <= fit_coord(cfg_data);
          end
          FLD_Y: begin
            r_sh_y[cfg_index] <= fit_coord(cfg_data);
            if (w_commit) r_act_y[cfg_index] <= fit_coord(cfg_data);
          end
          FLD_W: begin
            r_sh_w[cfg_index] <= fit_coord(cfg_data);
            if (w_commit) r_act_w[cfg_index] <= fit_coord(cfg_data);
          end
          FLD_H: begin
            r_sh_h[cfg_index] <= fit_coord(cfg_data);
            if (w_commit) r_act_h[cfg_index] <= fit_coord(cfg_data);
          end
          FLD_COLOR: begin
            r_sh_c[cfg_index] <= fit_color(cfg_data);
            if (w_commit) r_act_c[cfg_index] <= fit_color(cfg_data);
          end
          FLD_BG: begin
            r_sh_bg <= fit_color(cfg_data);
            if (w_commit) r_act_bg <= fit_color(cfg_data);
          end
          default: ;
        endcase
      end
    end
  end

  // ---- stage 1: register accepted pixel ----
  // Stage 1 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else if (w_adv) r_vld_p1 <= w_accept;
  end

  // Stage 1 coordinates
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_px_p1 <= pix_x;
      r_py_p1 <= pix_y;
    end
  end

  // ---- stage 2: hit flags and priority mux ----
  // One comparator set per rectangle against the active table
  always_comb begin
    w_hit = '0;
    w_ids = '0;
    for (int i = 0; i < RECT_COUNT; i++) begin
      w_hit[i] = rect_hit(r_px_p1, r_py_p1, r_act_x[i], r_act_y[i], r_act_w[i], r_act_h[i]);
      w_ids[i] = RECT_COUNT_WIDTH'(i);
    end
  end

  btree_mux #(
    .N  (RECT_COUNT),
    .DW (RECT_COUNT_WIDTH)
  ) u_btree_mux (
    .flags_in (w_hit),
    .data_in  (w_ids),
    .flag_out (w_any_hit),
    .data_out (w_win_idx)
  );

  // Stage 2 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p2 <= 1'b0;
    else if (w_adv) r_vld_p2 <= r_vld_p1;
  end

  // Stage 2 winner
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_hit_p2 <= w_any_hit;
      r_idx_p2 <= w_win_idx;
    end
  end

  // ---- stage 3: color lookup into output registers ----
  assign w_hit_out = r_vld_p2 && r_hit_p2;

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_index <= '0;
      out_color <= '0;
    end else if (w_adv) begin
      out_valid <= r_vld_p2;
      out_hit   <= w_hit_out;
      out_index <= w_hit_out ? r_idx_p2 : '0;
      out_color <= w_hit_out ? r_act_c[r_idx_p2] : r_act_bg;
    end
  end

endmodule
